// File: rtl/sdram_read_arbiter_if.sv
// sdram_read_arbiter_if: Avalon-MM pipelined read port bundle.
interface sdram_read_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              wait_request;
  logic [DATA_W-1:0] read_data;
  logic              read_data_valid;
  modport master (output address, read, input wait_request, read_data, read_data_valid);
  modport slave (input address, read, output wait_request, read_data, read_data_valid);
endinterface

// File: rtl/sdram_read_arbiter.sv
// sdram_read_arbiter: two pipelined Avalon readers sharing one SDRAM read master, with in-order return routing.
module sdram_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_PENDING = 8,
  parameter int STARVE_LIMIT = 16,
  localparam int PW = $clog2(MAX_PENDING),
  localparam int CW = PW + 1,
  localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  sdram_read_arbiter_if.slave    m0,
  sdram_read_arbiter_if.slave    m1,
  sdram_read_arbiter_if.master   sdram,
  output logic [CW-1:0]          pending_count,
  output logic                   route_error
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic grant_q, grant, arb, full, accept, push, pop, head;
  logic [SW-1:0] starve_q, starve_d;
  logic [MAX_PENDING-1:0] owner_q;
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic route_err_q;
  // A stalled grant is frozen so the request stays stable across waitrequest.
  assign arb = m1.read && (!m0.read || starve_q == SW'(STARVE_LIMIT));
  assign grant = (state_q == HOLD) ? grant_q : arb;
  assign full = count_q == CW'(MAX_PENDING);
  assign sdram.address = grant ? m1.address : m0.address;
  assign sdram.read = (grant ? m1.read : m0.read) && !full;
  assign accept = sdram.read && !sdram.wait_request;
  assign m0.wait_request = !(accept && !grant);
  assign m1.wait_request = !(accept && grant);
  assign push = accept;
  assign pop = sdram.read_data_valid && count_q != '0;
  assign head = owner_q[rd_q];
  assign m0.read_data_valid = pop && !head;
  assign m1.read_data_valid = pop && head;
  assign m0.read_data = sdram.read_data;
  assign m1.read_data = sdram.read_data;
  assign pending_count = count_q;
  assign route_error = route_err_q;
  always_comb begin
    state_d = IDLE;
    starve_d = starve_q;
    state_d = (sdram.read && sdram.wait_request) ? HOLD : IDLE;
    starve_d = (!m1.read || (accept && grant)) ? '0 :
               (accept && starve_q != SW'(STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      starve_q <= '0;
      owner_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      route_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant;
      starve_q <= starve_d;
      if (push) owner_q[wr_q] <= grant;
      wr_q <= wr_q + PW'(push);
      rd_q <= rd_q + PW'(pop);
      count_q <= count_q + CW'(push) - CW'(pop);
      route_err_q <= route_err_q | (sdram.read_data_valid && count_q == '0);
    end
endmodule

// File: tb/tb_sdram_read_arbiter.sv
// tb_sdram_read_arbiter: table vectors, directed corner sequences and random traffic against a queue-based model.
module tb_sdram_read_arbiter;
  localparam int AW = 32, DW = 32, MP = 8, SL = 16;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] pending_count;
  logic route_error;
  always #5 clk = ~clk;
  sdram_read_arbiter_if #(AW, DW) m0_if();
  sdram_read_arbiter_if #(AW, DW) m1_if();
  sdram_read_arbiter_if #(AW, DW) sd_if();
  sdram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MP), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if), .sdram(sd_if),
    .pending_count(pending_count), .route_error(route_error)
  );
  int checks = 0, failures = 0;
  int q[$];
  int starve, lock_g;
  bit locked, rerr;
  typedef struct {bit r0, r1, sw, sr, sel, w0, w1;} vec_t;
  vec_t vt[8];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m0_if.read = 1'b0; m1_if.read = 1'b0; m0_if.address = '0; m1_if.address = '0;
    sd_if.wait_request = 1'b0; sd_if.read_data_valid = 1'b0; sd_if.read_data = '0;
    q.delete(); starve = 0; lock_g = 0; locked = 0; rerr = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  // One cycle: drive, compare every output against the model, then advance the model past the edge.
  task automatic step(input bit r0, input logic [31:0] a0, input bit r1, input logic [31:0] a1,
                      input bit sw, input bit dv, input logic [31:0] d, output bit acc0, output bit acc1);
    int g;
    bit full, sr, acc, v0, v1;
    @(negedge clk);
    m0_if.read = r0; m0_if.address = a0; m1_if.read = r1; m1_if.address = a1;
    sd_if.wait_request = sw; sd_if.read_data_valid = dv; sd_if.read_data = d;
    #1;
    g = locked ? lock_g : (r1 && (!r0 || starve == SL)) ? 1 : 0;
    full = q.size() == MP;
    sr = (g == 1 ? r1 : r0) && !full;
    acc = sr && !sw;
    v0 = dv && q.size() > 0 && q[0] == 0;
    v1 = dv && q.size() > 0 && q[0] == 1;
    chk("sdram_read", 64'(sd_if.read), 64'(sr));
    chk("sdram_address", 64'(sd_if.address), 64'(g == 1 ? a1 : a0));
    chk("m0_wait", 64'(m0_if.wait_request), 64'(!(acc && g == 0)));
    chk("m1_wait", 64'(m1_if.wait_request), 64'(!(acc && g == 1)));
    chk("m0_valid", 64'(m0_if.read_data_valid), 64'(v0));
    chk("m1_valid", 64'(m1_if.read_data_valid), 64'(v1));
    chk("pending_count", 64'(pending_count), 64'(q.size()));
    chk("route_error", 64'(route_error), 64'(rerr));
    if (v0) chk("m0_data", 64'(m0_if.read_data), 64'(d));
    if (v1) chk("m1_data", 64'(m1_if.read_data), 64'(d));
    if (dv) begin
      if (q.size() > 0) void'(q.pop_front());
      else rerr = 1;
    end
    if (acc) q.push_back(g);
    locked = sr && sw;
    lock_g = g;
    if (!r1 || (acc && g == 1)) starve = 0;
    else if (acc && starve < SL) starve++;
    acc0 = acc && g == 0;
    acc1 = acc && g == 1;
  endtask
  initial begin
    bit a0, a1, p0, p1;
    logic [31:0] ad0, ad1;
    vt[0] = '{0, 0, 0, 0, 0, 1, 1};
    vt[1] = '{1, 0, 0, 1, 0, 0, 1};
    vt[2] = '{0, 1, 0, 1, 1, 1, 0};
    vt[3] = '{1, 1, 0, 1, 0, 0, 1};
    vt[4] = '{1, 0, 1, 1, 0, 1, 1};
    vt[5] = '{0, 1, 1, 1, 1, 1, 1};
    vt[6] = '{1, 1, 1, 1, 0, 1, 1};
    vt[7] = '{0, 0, 1, 0, 0, 1, 1};
    rst = 1'b1;
    do_reset();
    #1;
    chk("reset_pending", 64'(pending_count), 64'(0));
    chk("reset_route_error", 64'(route_error), 64'(0));
    chk("reset_sdram_read", 64'(sd_if.read), 64'(0));
    chk("reset_valids", 64'({m0_if.read_data_valid, m1_if.read_data_valid}), 64'(0));
    for (int i = 0; i < 8; i++) begin
      do_reset();
      step(vt[i].r0, 32'h100, vt[i].r1, 32'h200, vt[i].sw, 1'b0, '0, a0, a1);
      chk("vec_sdram_read", 64'(sd_if.read), 64'(vt[i].sr));
      chk("vec_address", 64'(sd_if.address), 64'(vt[i].sel ? 32'h200 : 32'h100));
      chk("vec_m0_wait", 64'(m0_if.wait_request), 64'(vt[i].w0));
      chk("vec_m1_wait", 64'(m1_if.wait_request), 64'(vt[i].w1));
    end
    do_reset();
    step(1, 32'h100, 0, 0, 0, 0, '0, a0, a1);
    chk("single_accept", 64'(a0), 64'(1));
    step(0, 0, 0, 0, 0, 0, '0, a0, a1);
    chk("single_pending1", 64'(pending_count), 64'(1));
    step(0, 0, 0, 0, 0, 0, '0, a0, a1);
    step(0, 0, 0, 0, 0, 1, 32'hA5A5A5A5, a0, a1);
    chk("single_m0_valid", 64'(m0_if.read_data_valid), 64'(1));
    chk("single_m0_data", 64'(m0_if.read_data), 64'hA5A5A5A5);
    chk("single_m1_valid", 64'(m1_if.read_data_valid), 64'(0));
    step(0, 0, 0, 0, 0, 0, '0, a0, a1);
    chk("single_pending0", 64'(pending_count), 64'(0));
    do_reset();
    for (int i = 0; i < 34; i++) begin
      step(1, 32'h1000 + i, 1, 32'h2000 + i, 0, q.size() > 0, $urandom, a0, a1);
      chk("starve_order_p1", 64'(a1), 64'(i % 17 == 16));
      chk("starve_order_p0", 64'(a0), 64'(i % 17 != 16));
    end
    do_reset();
    step(1, 32'h100, 0, 32'h200, 1, 0, '0, a0, a1);
    chk("stall_addr", 64'(sd_if.address), 64'h100);
    for (int i = 0; i < 4; i++) begin
      step(1, 32'h100, 1, 32'h200, 1, 0, '0, a0, a1);
      chk("stall_addr", 64'(sd_if.address), 64'h100);
    end
    step(1, 32'h100, 1, 32'h200, 0, 0, '0, a0, a1);
    chk("stall_addr", 64'(sd_if.address), 64'h100);
    chk("stall_p0_first", 64'(a0), 64'(1));
    step(0, 32'h100, 1, 32'h200, 0, 0, '0, a0, a1);
    chk("stall_p1_next", 64'(a1), 64'(1));
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 32'h300 + i, 0, 0, 0, 0, '0, a0, a1);
    step(1, 32'h400, 0, 0, 0, 0, '0, a0, a1);
    chk("full_wait", 64'(m0_if.wait_request), 64'(1));
    chk("full_sdram_read", 64'(sd_if.read), 64'(0));
    chk("full_pending", 64'(pending_count), 64'(8));
    step(1, 32'h400, 0, 0, 0, 1, 32'h55, a0, a1);
    chk("full_no_accept", 64'(a0), 64'(0));
    step(1, 32'h400, 0, 0, 0, 0, '0, a0, a1);
    chk("full_pending7", 64'(pending_count), 64'(7));
    chk("full_next_accept", 64'(a0), 64'(1));
    while (q.size() > 0) step(0, 0, 0, 0, 0, 1, $urandom, a0, a1);
    do_reset();
    for (int i = 0; i < 4; i++) step(i % 2 == 0, 32'h10 + i, i % 2 == 1, 32'h20 + i, 0, 0, '0, a0, a1);
    for (int i = 0; i < 20; i++) begin
      p1 = 1'($urandom);
      step(!p1, 32'h500 + i, p1, 32'h600 + i, 0, 1, $urandom, a0, a1);
      chk("simul_pending4", 64'(pending_count), 64'(4));
    end
    do_reset();
    step(0, 0, 0, 0, 0, 1, 32'hDEAD, a0, a1);
    chk("empty_no_valid", 64'({m0_if.read_data_valid, m1_if.read_data_valid}), 64'(0));
    step(0, 0, 0, 0, 0, 0, '0, a0, a1);
    chk("route_error_set", 64'(route_error), 64'(1));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, '0, a0, a1);
    chk("route_error_held", 64'(route_error), 64'(1));
    do_reset();
    #1;
    chk("rst_route_error", 64'(route_error), 64'(0));
    chk("rst_pending", 64'(pending_count), 64'(0));
    p0 = 0; p1 = 0; ad0 = '0; ad1 = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!p0) begin p0 = $urandom_range(0, 9) < 7; ad0 = $urandom; end
      if (!p1) begin p1 = $urandom_range(0, 9) < 6; ad1 = $urandom; end
      step(p0, ad0, p1, ad1, $urandom_range(0, 9) < 3, q.size() > 0 && $urandom_range(0, 9) < 4, $urandom, a0, a1);
      if (a0) p0 = 0;
      if (a1) p1 = 0;
    end
    do_reset();
    #1;
    chk("final_rst_pending", 64'(pending_count), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sdram_read_arbiter.md
Name: sdram_read_arbiter

Overview:
- Shares the single SDRAM Avalon-MM read master between two pipelined read requesters: port 0 (VGA scanout, latency-critical) and port 1 (GPU/other reader).
- Arbitrates requests and holds the grant stable across waitrequest.
- Records the owner of every accepted read in an in-order routing FIFO, and steers each returning readdatavalid to the correct requester.
- Sits between the VGA controller's master port and the SDRAM controller slave.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, read data width of all ports.
- MAX_PENDING, 8, maximum accepted-but-unreturned reads; routing FIFO depth; power of 2, ≥2.
- STARVE_LIMIT, 16, consecutive port-0 acceptances tolerated while port 1 is requesting before port 1 is forced through once; ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- m0_address  in  ADDR_W  port 0 read address
- m0_read  in  1  port 0 read request
- m0_wait_request  out  1  port 0 stall
- m0_read_data  out  DATA_W  port 0 return data
- m0_read_data_valid  out  1  port 0 return strobe
- m1_address  in  ADDR_W  port 1 read address
- m1_read  in  1  port 1 read request
- m1_wait_request  out  1  port 1 stall
- m1_read_data  out  DATA_W  port 1 return data
- m1_read_data_valid  out  1  port 1 return strobe
- sdram_address  out  ADDR_W  downstream address
- sdram_read  out  1  downstream read
- sdram_read_data  in  DATA_W  downstream data
- sdram_wait_request  in  1  downstream stall
- sdram_read_data_valid  in  1  downstream return strobe
- pending_count  out  $clog2(MAX_PENDING)+1  outstanding reads
- route_error  out  1  sticky: valid arrived with routing FIFO empty

Behaviour:
- Reset is asynchronous, active-high on rst; clock is clk.
- Reset values: lock=0, grant=0, starve counter=0, FIFO empty, pending_count=0, route_error=0.
  - With no request active, sdram_read=0 and both *_read_data_valid=0.
  - mN_wait_request=1 whenever that port is not being accepted.
- Arbitration applies when lock=0.
  - grant=1 if m1_read and (!m0_read or starve==STARVE_LIMIT); otherwise grant=0 if m0_read.
  - If neither port requests, sdram_read=0.
- Lock (HOLD state):
  - Entered when sdram_read && sdram_wait_request. The current grant is frozen next cycle.
  - Exited in the cycle the read is accepted.
  - A port that deasserts read while locked violates Avalon. Behaviour is undefined, but the arbiter must not deadlock: lock is released when the granted read drops.
- Mux: sdram_address = granted port's address (combinational). sdram_read = granted port's read && !full.
- Accept = sdram_read && !sdram_wait_request.
  - The granted port's wait_request = !accept; the other port's wait_request = 1.
  - No extra latency: combinational path from sdram_wait_request.
- On accept, the grant id is pushed into the routing FIFO.
- Return path:
  - On sdram_read_data_valid, pop the FIFO head.
  - Assert mH_read_data_valid for head owner H in the same cycle (combinational from FIFO head).
  - sdram_read_data is broadcast unregistered to both mN_read_data.
- Full: pending_count==MAX_PENDING forces sdram_read=0 and both wait_request=1. An accept and a return in the same cycle at full is impossible because sdram_read=0.
- Simultaneous push and pop: pending_count unchanged; FIFO pointers both advance and wrap modulo MAX_PENDING.
- Return with FIFO empty: data dropped, no valid asserted, route_error set until rst.
- Starve counter:
  - Increments on each port-0 accept while m1_read=1, saturating at STARVE_LIMIT.
  - Clears on a port-1 accept, or on any cycle with m1_read=0.
- Reset mid-operation: all state cleared immediately. Returns still in flight from SDRAM after reset release land in an empty FIFO and set route_error; the system resets the SDRAM controller together with this block.

Test Plan:
- Single port-0 read of 0x100, sdram_wait_request low, data 0xA5A5A5A5 returned 3 cycles later -> m0_wait_request low for 1 cycle, m0_read_data_valid=1 with 0xA5A5A5A5, m1 valid stays 0, pending_count 0->1->0.
- Both ports request continuously, no stalls, STARVE_LIMIT=16 -> acceptance order is 16×port 0, then 1×port 1, repeating. Returns are routed in identical order.
- Port 0 requests, sdram_wait_request held high 5 cycles; port 1 asserts read during the stall -> sdram_address stays m0_address for all 6 cycles. Port 0 accepted first; port 1 accepted on the next cycle.
- Issue 8 reads with no returns (MAX_PENDING=8) -> 9th request sees wait_request=1 and sdram_read=0. One return drops pending_count to 7; the next accept occurs the following cycle.
- At pending_count=4, drive an accept and a return in the same cycle, repeated for 20 cycles across FIFO wrap -> pending_count stays 4 and every return reaches its correct owner.
- Pulse sdram_read_data_valid with nothing outstanding -> no mN valid, route_error=1 and held. Assert rst -> route_error=0, pending_count=0.
